// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA speed-adjust input stage.
package vga_pkg;

  localparam int unsigned SPEED_W    = 3;
  localparam int unsigned SPEED_MAX  = 7;
  localparam int unsigned SPEED_INIT = 2;
  localparam int unsigned FCNT_W     = SPEED_W + 1;

  localparam int unsigned BTN_FAST = 0;
  localparam int unsigned BTN_SLOW = 1;

  typedef logic [SPEED_W-1:0] speed_t;

  // Frames per move tick: highest speed ticks every frame, speed 0 every SPEED_MAX+1 frames.
  function automatic logic [FCNT_W-1:0] frame_div(input speed_t s);
    return FCNT_W'(SPEED_MAX) - FCNT_W'(s) + FCNT_W'(1);
  endfunction

endpackage

// File: rtl/push_debounce.sv
// One push button: two-flop synchroniser followed by a stability-window debouncer.
module push_debounce #(
  parameter int unsigned DB_COUNT = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_db
);

  localparam int unsigned CNT_W = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after it has differed for DB_COUNT consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (r_s2 != r_db) begin
      if (r_cnt == CNT_LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/speed_ctrl.sv
// Button-driven speed level and frame-synchronous move strobe for pixelGeneration.
module speed_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned DB_COUNT  = 500000,
  parameter logic        VSYNC_ACT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         push,
  input  logic               vsync,
  output logic [1:0]         push_db,
  output logic [SPEED_W-1:0] speed,
  output logic               move_tick
);

  logic [1:0]        w_db;
  logic [1:0]        r_db_q;
  logic [1:0]        r_press;
  speed_t            r_speed;
  logic              r_vs_q;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_tick;
  logic [FCNT_W-1:0] w_div;
  logic              w_frame_edge;
  logic              w_tick_due;

  push_debounce #(.DB_COUNT(DB_COUNT)) u_db_fast (
    .clk   (clk),
    .rst   (rst),
    .i_raw (push[BTN_FAST]),
    .o_db  (w_db[BTN_FAST])
  );

  push_debounce #(.DB_COUNT(DB_COUNT)) u_db_slow (
    .clk   (clk),
    .rst   (rst),
    .i_raw (push[BTN_SLOW]),
    .o_db  (w_db[BTN_SLOW])
  );

  // Turn debounced rising edges into single-cycle press pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_q  <= 2'b00;
      r_press <= 2'b00;
    end else begin
      r_db_q  <= w_db;
      r_press <= w_db & ~r_db_q;
    end
  end

  // Saturating speed step; simultaneous presses cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_speed <= speed_t'(SPEED_INIT);
    end else if (r_press[BTN_FAST] && !r_press[BTN_SLOW]) begin
      if (r_speed < speed_t'(SPEED_MAX)) begin
        r_speed <= r_speed + speed_t'(1);
      end
    end else if (r_press[BTN_SLOW] && !r_press[BTN_FAST]) begin
      if (r_speed != '0) begin
        r_speed <= r_speed - speed_t'(1);
      end
    end
  end

  assign w_div        = frame_div(r_speed);
  assign w_frame_edge = (vsync == VSYNC_ACT) && (r_vs_q != VSYNC_ACT);
  // ">=" lets a speed-up mid-interval fire immediately instead of skipping a period.
  assign w_tick_due   = (r_frame_cnt >= (w_div - FCNT_W'(1)));

  // Count frames and strobe move_tick once every div frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_q      <= 1'b0;
      r_frame_cnt <= '0;
      r_tick      <= 1'b0;
    end else begin
      r_vs_q <= vsync;
      r_tick <= 1'b0;
      if (w_frame_edge) begin
        if (w_tick_due) begin
          r_tick      <= 1'b1;
          r_frame_cnt <= '0;
        end else begin
          r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
        end
      end
    end
  end

  assign push_db   = w_db;
  assign speed     = r_speed;
  assign move_tick = r_tick;

endmodule

// File: tb/tb_speed_ctrl.sv
// Directed bench for speed_ctrl: debounce, saturating speed steps and move_tick spacing.
module tb_speed_ctrl;
  import vga_pkg::*;

  localparam int unsigned DB = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         push;
  logic               vsync;
  logic [1:0]         push_db;
  logic [SPEED_W-1:0] speed;
  logic               move_tick;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   fe_cnt = 0;
  int   phase = 2;
  int   stray = 0;
  logic vs_seen = 1'b0;
  logic fe_now  = 1'b0;
  logic tick_now = 1'b0;

  always #5 clk = ~clk;

  speed_ctrl #(.DB_COUNT(DB), .VSYNC_ACT(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .vsync     (vsync),
    .push_db   (push_db),
    .speed     (speed),
    .move_tick (move_tick)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: track frame edges as the DUT sees them, sample outputs, then advance vsync.
  task automatic step();
    @(posedge clk);
    fe_now  = !rst && (vsync == 1'b0) && (vs_seen == 1'b1);
    vs_seen = rst ? 1'b0 : vsync;
    #1;
    cyc++;
    if (fe_now) fe_cnt++;
    tick_now = move_tick;
    if (move_tick && !fe_now) stray++;
    phase = (phase == 19) ? 0 : phase + 1;
    vsync = (phase < 2) ? 1'b0 : 1'b1;
  endtask

  task automatic wait_tick(output int fe_at, output int cyc_at);
    logic found;
    found  = 1'b0;
    fe_at  = -1;
    cyc_at = -1;
    for (int n = 0; n < 2000 && !found; n++) begin
      step();
      if (tick_now) begin
        found  = 1'b1;
        fe_at  = fe_cnt;
        cyc_at = cyc;
      end
    end
    if (!found) check("tick_timeout", 0, 1);
  endtask

  task automatic wait_fe();
    logic found;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      step();
      if (fe_now) found = 1'b1;
    end
    if (!found) check("fe_timeout", 0, 1);
  endtask

  task automatic press(input logic [1:0] m);
    push = m;
    repeat (10) step();
    push = 2'b00;
    repeat (10) step();
  endtask

  initial begin
    int fa, ca, fb, cb, fc, cc, n;
    logic [1:0] seen;

    rst   = 1'b1;
    push  = 2'b00;
    vsync = 1'b1;

    // Reset values and first tick after six frame edges (div = 6).
    repeat (3) step();
    check("rst_speed", speed, 2);
    check("rst_db", push_db, 0);
    check("rst_tick", move_tick, 0);
    rst = 1'b0;
    fe_cnt = 0;
    wait_tick(fa, ca);
    check("first_tick_fe", fa, 6);

    // Glitch shorter than the debounce window.
    push = 2'b10;
    repeat (3) step();
    push = 2'b00;
    seen = 2'b00;
    repeat (10) begin
      step();
      seen = seen | push_db;
    end
    check("glitch_db", seen, 0);
    check("glitch_speed", speed, 2);

    // Clean press held for 20 cycles.
    push = 2'b01;
    n = 0;
    do begin
      step();
      n++;
    end while (!push_db[0] && n < 50);
    check("db_latency", n, 6);
    step();
    check("speed_pre", speed, 2);
    step();
    check("speed_step", speed, 3);
    repeat (12) step();
    push = 2'b00;
    repeat (10) step();
    check("hold_once", speed, 3);
    check("release_db", push_db, 0);

    // Saturate upward, then one tick per frame.
    for (int i = 0; i < 5; i++) begin
      press(2'b01);
      check("sat_up", speed, (i < 4) ? 4 + i : 7);
    end
    wait_tick(fa, ca);
    wait_tick(fb, cb);
    check("max_fe_gap", fb - fa, 1);
    check("max_cyc_gap", cb - ca, 20);

    // Saturate downward, then ticks every 8 frames.
    for (int i = 0; i < 6; i++) begin
      press(2'b10);
      check("down", speed, 6 - i);
    end
    press(2'b10);
    check("sat_down0", speed, 0);
    press(2'b10);
    check("sat_down1", speed, 0);
    wait_tick(fa, ca);
    wait_tick(fb, cb);
    check("min_fe_gap", fb - fa, 8);
    check("min_cyc_gap", cb - ca, 160);

    // Simultaneous presses cancel.
    press(2'b11);
    check("both", speed, 0);
    press(2'b01);
    press(2'b01);
    check("back_to_2", speed, 2);

    // Speed-up with frame_cnt already at 4: tick on the very next edge, then every 5.
    wait_tick(fa, ca);
    repeat (4) wait_fe();
    push = 2'b01;
    repeat (10) step();
    push = 2'b00;
    check("mid_speed", speed, 3);
    wait_tick(fb, cb);
    check("mid_tick_fe", fb - fa, 5);
    wait_tick(fc, cc);
    check("mid_period_fe", fc - fb, 5);
    check("mid_period_cyc", cc - cb, 100);

    // Reset mid-debounce and mid-interval discards everything.
    push = 2'b01;
    repeat (3) step();
    rst  = 1'b1;
    push = 2'b00;
    repeat (2) step();
    check("rst2_speed", speed, 2);
    check("rst2_tick", move_tick, 0);
    rst = 1'b0;
    fe_cnt = 0;
    repeat (12) step();
    check("rst2_db", push_db, 0);
    wait_tick(fa, ca);
    check("rst2_first_fe", fa, 6);

    check("stray_ticks", stray, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/speed_ctrl.md
Name: speed_ctrl

Overview:
- Upstream input stage for the VGA speed-adjust design; sits between the raw push buttons and pixelGeneration.
- Synchronises and debounces push[1:0] and converts each press into a saturating speed-level change.
- Emits a one-cycle move_tick on selected frame boundaries, derived from vsync. pixelGeneration uses it to advance animated objects, so object speed follows the speed level.

Parameters:
- DB_COUNT, 500000: debounce stability window in clk cycles (10 ms at 50 MHz); simulation uses 4.
- SPEED_W, 3: width of the speed level.
- SPEED_MAX, 7: highest speed level; must be < 2**SPEED_W.
- SPEED_INIT, 2: speed level loaded at reset.
- VSYNC_ACT, 0: active level of vsync (0 = active-low).

Ports:
- clk  input  1  system clock, single domain.
- rst  input  1  synchronous, active-high reset.
- push  input  2  raw asynchronous buttons, high = pressed; [0] = faster, [1] = slower.
- vsync  input  1  vertical sync from vgaSync.
- push_db  output  2  debounced, synchronised button levels.
- speed  output  SPEED_W  current speed level, 0..SPEED_MAX.
- move_tick  output  1  one-cycle pulse; object-advance strobe.

Behaviour:
- Reset, synchronous on rst high at a clk edge, overriding all else:
  - speed=SPEED_INIT; push_db=0; move_tick=0.
  - Synchroniser flops, debounce counters, vsync delay flop and frame counter all cleared to 0.
- Synchroniser: each push bit passes through 2 flops (s2) before the debounce logic.
- Debounce (per bit, independent):
  - If s2 != push_db, the counter increments; otherwise it clears.
  - When the counter equals DB_COUNT-1 and s2 still differs, push_db takes s2 and the counter clears.
  - Net latency from a clean raw edge to the push_db change is 2 + DB_COUNT cycles.
  - Any glitch shorter than DB_COUNT cycles leaves push_db unchanged.
- Press event: a 0->1 transition of push_db[i], registered as a 1-cycle pulse (press[i]); release is ignored.
- Speed update, applied in the cycle after the press pulse:
  - press[0] alone: speed+1, saturating at SPEED_MAX.
  - press[1] alone: speed-1, saturating at 0.
  - Both in the same cycle: no change.
  - A held button produces exactly one step.
- Frame edge:
  - vsync is registered once; frame_edge = (vsync==VSYNC_ACT) && (vsync_q!=VSYNC_ACT).
  - Exactly one frame_edge per frame. vsync held at the active level after reset yields no edge until it deasserts and reasserts.
- Tick generation:
  - div = SPEED_MAX - speed + 1, giving a range of 1..SPEED_MAX+1 frames.
  - On frame_edge: if frame_cnt >= div-1, move_tick=1 in the next cycle and frame_cnt clears to 0; otherwise frame_cnt increments.
  - move_tick is high for exactly 1 cycle and is low at all other times.
  - frame_cnt width = SPEED_W+1 bits.
- Speed change mid-interval: the new div takes effect at the next frame_edge. If frame_cnt already satisfies frame_cnt >= div-1, the tick fires on that edge; no tick is ever skipped past the new period.
- Press pulse and frame_edge in the same cycle: the tick decision uses the pre-update speed.
- rst asserted mid-debounce or mid-interval: all state discarded. The first tick after release needs a full div frames, counting only frame_edges seen after reset.

Decomposition:
- Shared package vga_pkg:
  - speed constants SPEED_W, SPEED_MAX, SPEED_INIT;
  - typedef speed_t = logic [SPEED_W-1:0];
  - index constants BTN_FAST=0 and BTN_SLOW=1.
- One sub-module, push_debounce: a 1-bit synchroniser plus debounce counter with parameter DB_COUNT. It is instantiated twice.
  - It is also the replacement for the debounce that is currently disabled in the top level.
- The top level then wires push_db/move_tick/speed into pixelGeneration in place of raw push.

Test Plan (DB_COUNT=4, SPEED_MAX=7, SPEED_INIT=2; vsync active-low, period 20 cycles):
- Reset values: rst high 3 cycles -> speed=2, push_db=0, move_tick=0. The first tick arrives on the 6th frame_edge after reset (div=6).
- Clean press: push[0] high 20 cycles -> push_db[0] rises exactly 6 cycles after the raw edge; speed goes 2->3 one cycle after the press pulse, and only once despite the hold.
- Glitch rejection: push[1] high 3 cycles, then low -> push_db stays 0 and speed stays 2.
- Saturation up: 7 separate presses of push[0] -> speed 3,4,5,6,7,7,7; at speed=7, move_tick fires on every frame_edge (20-cycle spacing).
- Saturation down: from speed=1, press push[1] twice -> speed 0 then 0; ticks spaced 8 frames (160 cycles).
- Simultaneous press and mid-interval change:
  - push[0] and push[1] rising together -> speed unchanged.
  - Then with speed=2 and frame_cnt=4, press faster (div becomes 5) -> move_tick on the very next frame_edge, then every 5 frames.
